// File: rtl/twos_to_signmag_serial_pkg.sv
// Shared definitions for the serial two's-complement to sign-magnitude converter.
// Holds the FSM state encoding and the default operand width.
package twos_to_signmag_serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_inc_cell.sv
// One bit of invert-and-increment: mag = ~op + carry, rippling the carry.
// Purely combinational; the top reuses a single instance across bit positions.
module serial_inc_cell (
    input  logic op_bit,
    input  logic carry_in,
    output logic mag_bit,
    output logic carry_out
);

    assign mag_bit   = (~op_bit) ^ carry_in;
    assign carry_out = (~op_bit) & carry_in;

endmodule

// File: rtl/twos_to_signmag_serial.sv
// Serial two's-complement to sign-magnitude converter, one magnitude bit per cycle.
// Negative operands walk bits 0..WIDTH-2 through a single serial_inc_cell.
module twos_to_signmag_serial
    import twos_to_signmag_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             ovf
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 2);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-2:0] mag;
    logic [WIDTH-2:0] mag_full;
    logic             mag_bit;
    logic             carry_out;
    logic             last_bit;

    assign last_bit = (cnt == LAST);

    serial_inc_cell u_cell (
        .op_bit    (op[cnt]),
        .carry_in  (carry),
        .mag_bit   (mag_bit),
        .carry_out (carry_out)
    );

    // Magnitude including the bit being produced this cycle, so the final
    // result can be loaded on the same edge that leaves CONV.
    always_comb begin
        mag_full      = mag;
        mag_full[cnt] = mag_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = din[WIDTH-1] ? CONV : DONE;
            CONV:    if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Results land on the edge entering DONE, so dout/ovf are valid with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            mag   <= '0;
            dout  <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= din;
                        cnt   <= '0;
                        carry <= 1'b1;
                        mag   <= '0;
                        if (!din[WIDTH-1]) begin
                            dout <= din;
                            ovf  <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    mag   <= mag_full;
                    carry <= carry_out;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // Carry out of the top magnitude bit means din was the most-negative value.
                        ovf  <= carry_out;
                        dout <= carry_out ? '1 : {1'b1, mag_full};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
